// File: rtl/mem_io_bridge_pkg.sv
// Shared decode constants and source-select encoding for the CPU memory bridge.
// The I/O window is the top quarter of the 256 KB decode range.
package mem_io_bridge_pkg;

    localparam logic [17:0] IO_BASE      = 18'h30000;
    localparam logic [1:0]  IO_SEL       = IO_BASE[17:16];
    localparam logic [15:0] IO_OFS_UART  = 16'h0000;
    localparam logic [15:0] IO_OFS_HALT  = 16'h0004;

    localparam int TX_DEPTH_DEF = 16;
    localparam int RX_DEPTH_DEF = 16;

    typedef enum logic {
        SRC_RAM = 1'b0,
        SRC_IO  = 1'b1
    } src_t;

    function automatic logic addr_is_io(input logic [17:0] a);
        return a[17:16] == IO_SEL;
    endfunction

endpackage

// File: rtl/mem_io_bridge_sync_fifo.sv
// Single-clock FIFO with show-ahead read data; DEPTH must be a power of two.
// A pop is accounted before a push, so a full FIFO accepts a push in a draining cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/mem_io_bridge.sv
// CPU byte-port bridge: RAM/I/O decode, UART TX/RX buffering, cycle counter
// with snapshot, halt/program-done, and one-cycle read return.
module mem_io_bridge
    import mem_io_bridge_pkg::*;
#(
    parameter int TX_DEPTH = TX_DEPTH_DEF,
    parameter int RX_DEPTH = RX_DEPTH_DEF,
    parameter int RAM_AW   = 17
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [31:0]       cpu_a,
    input  logic              cpu_wr,
    input  logic [7:0]        cpu_dout,
    output logic [7:0]        cpu_din,
    output logic              io_buffer_full,
    output logic [RAM_AW-1:0] ram_a,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              program_done,
    output logic              tx_overflow
);

    localparam int TXCW = $clog2(TX_DEPTH) + 1;
    localparam int RXCW = $clog2(RX_DEPTH) + 1;

    logic            sel_io;
    logic [15:0]     ofs;
    logic            is_uart;
    logic            is_halt;
    logic            rd_req;
    logic            wr_req;

    logic            tx_push;
    logic            tx_pop;
    logic [7:0]      tx_wdata;
    logic            tx_full;
    logic            tx_empty;
    logic [TXCW-1:0] tx_count;

    logic            rx_pop;
    logic [7:0]      rx_rdata;
    logic            rx_full;
    logic            rx_empty;
    logic [RXCW-1:0] rx_count;

    logic [7:0]      io_byte;
    src_t            sel_q;
    logic [7:0]      io_q;
    logic            rd_q;
    logic [7:0]      hold_q;
    logic [31:0]     snap_q;
    logic [31:0]     cnt_q;
    logic            halt_q;

    assign sel_io  = addr_is_io(cpu_a[17:0]);
    assign ofs     = cpu_a[15:0];
    assign is_uart = sel_io && (ofs == IO_OFS_UART);
    assign is_halt = sel_io && (ofs == IO_OFS_HALT);
    assign rd_req  = rdy_in & ~cpu_wr;
    assign wr_req  = rdy_in & cpu_wr;

    assign ram_a     = cpu_a[RAM_AW-1:0];
    assign ram_we    = wr_req & ~sel_io;
    assign ram_wdata = cpu_dout;

    // The halt write pushes a 0x00 marker that bypasses the zero filter.
    assign tx_push  = wr_req & ((is_uart & (cpu_dout != 8'h00)) | is_halt);
    assign tx_wdata = is_halt ? 8'h00 : cpu_dout;
    assign tx_valid = ~tx_empty;
    assign tx_pop   = tx_valid & tx_ready;
    assign rx_pop   = rd_req & is_uart & ~rx_empty;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (tx_wdata),
        .rdata (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .push  (rx_valid),
        .pop   (rx_pop),
        .wdata (rx_data),
        .rdata (rx_rdata),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    always_comb begin
        io_byte = 8'h00;
        if (sel_io) begin
            case (ofs)
                IO_OFS_UART:         io_byte = rx_empty ? 8'h00 : rx_rdata;
                IO_OFS_HALT:         io_byte = cnt_q[7:0];
                IO_OFS_HALT + 16'd1: io_byte = snap_q[15:8];
                IO_OFS_HALT + 16'd2: io_byte = snap_q[23:16];
                IO_OFS_HALT + 16'd3: io_byte = snap_q[31:24];
                default:             io_byte = 8'h00;
            endcase
        end
    end

    // RAM data arrives one cycle late, so the mux sits after the register stage;
    // hold_q keeps the last returned byte stable when no read was issued.
    assign cpu_din = rd_q ? ((sel_q == SRC_RAM) ? ram_rdata : io_q) : hold_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sel_q          <= SRC_RAM;
            io_q           <= 8'h00;
            rd_q           <= 1'b0;
            hold_q         <= 8'h00;
            snap_q         <= 32'h0;
            cnt_q          <= 32'h0;
            halt_q         <= 1'b0;
            tx_overflow    <= 1'b0;
            program_done   <= 1'b0;
            io_buffer_full <= 1'b0;
        end else begin
            rd_q   <= rd_req;
            hold_q <= cpu_din;
            if (rd_req) begin
                sel_q <= sel_io ? SRC_IO : SRC_RAM;
                io_q  <= io_byte;
                if (is_halt) snap_q <= cnt_q;
            end
            if (rdy_in && !halt_q) cnt_q <= cnt_q + 32'd1;
            if (wr_req && is_halt) halt_q <= 1'b1;
            if (tx_push && tx_full && !tx_pop) tx_overflow <= 1'b1;
            program_done   <= halt_q & tx_empty;
            io_buffer_full <= (tx_count >= TXCW'(TX_DEPTH - 2));
        end
    end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge: read and TX scoreboards checked by monitors,
// plus direct checks of the status outputs.
module tb_mem_io_bridge;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] cpu_a;
    logic        cpu_wr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [16:0] ram_a;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        program_done;
    logic        tx_overflow;

    mem_io_bridge dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .cpu_a          (cpu_a),
        .cpu_wr         (cpu_wr),
        .cpu_dout       (cpu_dout),
        .cpu_din        (cpu_din),
        .io_buffer_full (io_buffer_full),
        .ram_a          (ram_a),
        .ram_we         (ram_we),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .program_done   (program_done),
        .tx_overflow    (tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  rd_exp[$];
    logic [7:0]  tx_exp[$];
    logic        mark = 1'b0;
    logic        mark_q = 1'b0;
    logic [31:0] m_cnt = 32'h0;
    logic        m_halt = 1'b0;
    logic [31:0] snap;
    logic [7:0]  ram_mem [0:131071];

    initial begin
        for (int i = 0; i < 131072; i++) ram_mem[i] = 8'h00;
    end

    always @(posedge clk_in) begin
        if (ram_we) ram_mem[ram_a] <= ram_wdata;
        ram_rdata <= ram_mem[ram_a];
    end

    // Reference cycle counter: counts accepted cycles until a halt write is accepted.
    always @(posedge clk_in) begin
        if (rst_in) begin
            m_cnt  <= 32'h0;
            m_halt <= 1'b0;
        end else if (rdy_in) begin
            if (!m_halt) m_cnt <= m_cnt + 32'd1;
            if (cpu_wr && cpu_a[17:0] == 18'h30004) m_halt <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk_in) mark_q <= mark & rdy_in & ~rst_in;

    always @(negedge clk_in) begin
        if (mark_q) begin
            if (rd_exp.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL rd_unexpected: got %02h, no read pending", cpu_din);
            end else begin
                check("cpu_din", {24'h0, cpu_din}, {24'h0, rd_exp.pop_front()});
            end
        end
    end

    always @(negedge clk_in) begin
        if (!rst_in && tx_valid && tx_ready) begin
            if (tx_exp.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL tx_unexpected: got %02h, none expected", tx_data);
            end else begin
                check("tx_data", {24'h0, tx_data}, {24'h0, tx_exp.pop_front()});
            end
        end
    end

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        cpu_a  = 32'h0;
        cpu_wr = 1'b0;
        mark   = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        cpu_a = a; cpu_wr = 1'b1; cpu_dout = d;
        cyc();
        idle();
    endtask

    task automatic tx_wr(input logic [7:0] d);
        if (d != 8'h00) tx_exp.push_back(d);
        wr(32'h30000, d);
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] exp);
        cpu_a = a; cpu_wr = 1'b0; mark = 1'b1;
        rd_exp.push_back(exp);
        cyc();
        idle();
    endtask

    task automatic rd_snap();
        snap = m_cnt;
        rd(32'h30004, m_cnt[7:0]);
    endtask

    task automatic wait_tx_empty(input string name);
        logic done;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk_in);
            if (!tx_valid) done = 1'b1;
        end
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL %s: tx_valid still 1 after 100 cycles, expected 0", name);
        end
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; cpu_dout = 8'h00;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        idle();
        repeat (3) cyc();
        @(negedge clk_in);
        check("rst_cpu_din", {24'h0, cpu_din}, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_prog_done", {31'h0, program_done}, 32'h0);
        check("rst_buf_full", {31'h0, io_buffer_full}, 32'h0);
        check("rst_overflow", {31'h0, tx_overflow}, 32'h0);
        cyc();
        rst_in = 1'b0;

        // RAM write/read, including the top RAM byte
        wr(32'h00123, 8'hA5);
        rd(32'h00123, 8'hA5);
        wr(32'h1FFFF, 8'h3C);
        rd(32'h1FFFF, 8'h3C);
        rd(32'h00123, 8'hA5);

        // UART output "Hi\0": the terminating zero never reaches the transmitter
        tx_ready = 1'b1;
        tx_wr(8'h48); tx_wr(8'h69); tx_wr(8'h00);
        wr(32'h30100, 8'h77);
        repeat (4) cyc();
        @(negedge clk_in);
        check("hi_tx_idle", {31'h0, tx_valid}, 32'h0);
        check("hi_tx_drained", tx_exp.size(), 32'h0);
        cyc();

        // TX backpressure and overflow
        tx_ready = 1'b0;
        for (int i = 1; i <= 13; i++) tx_wr(8'(i));
        cyc();
        @(negedge clk_in);
        check("full_at_13", {31'h0, io_buffer_full}, 32'h0);
        cyc();
        tx_wr(8'd14);
        cyc();
        @(negedge clk_in);
        check("full_at_14", {31'h0, io_buffer_full}, 32'h1);
        cyc();
        tx_wr(8'd15); tx_wr(8'd16);
        @(negedge clk_in);
        check("ovf_before_drop", {31'h0, tx_overflow}, 32'h0);
        cyc();
        wr(32'h30000, 8'd17);
        @(negedge clk_in);
        check("ovf_after_drop", {31'h0, tx_overflow}, 32'h1);
        cyc();
        tx_ready = 1'b1;
        wait_tx_empty("bp_drain");
        cyc();
        check("bp_all_sent", tx_exp.size(), 32'h0);
        check("bp_buf_free", {31'h0, io_buffer_full}, 32'h0);

        // Cycle counter snapshot and byte reads
        rd_snap();
        repeat (7) cyc();
        rd_snap();
        rd(32'h30005, snap[15:8]);
        rd(32'h30006, snap[23:16]);
        rd(32'h30007, snap[31:24]);
        rd(32'h30008, 8'h00);

        // rdy_in low: cpu_din holds, no push, no RAM write, counter paused
        rd_snap();
        rdy_in = 1'b0; cpu_a = 32'h30000; cpu_wr = 1'b1; cpu_dout = 8'h55;
        cyc();
        @(negedge clk_in);
        check("din_hold", {24'h0, cpu_din}, {24'h0, snap[7:0]});
        check("rdy0_no_push", {31'h0, tx_valid}, 32'h0);
        cyc();
        cpu_a = 32'h00050;
        @(negedge clk_in);
        check("rdy0_no_ram_we", {31'h0, ram_we}, 32'h0);
        cyc();
        @(negedge clk_in);
        check("din_hold2", {24'h0, cpu_din}, {24'h0, snap[7:0]});
        cyc();
        rdy_in = 1'b1;
        idle();
        rd(32'h00050, 8'h00);
        rd_snap();

        // RX path, including a read colliding with a push into an empty FIFO
        rx_valid = 1'b1; rx_data = 8'h41;
        cyc();
        rx_valid = 1'b0;
        rd(32'h30000, 8'h41);
        rd(32'h30000, 8'h00);
        rx_valid = 1'b1; rx_data = 8'h42;
        rd(32'h30000, 8'h00);
        rx_valid = 1'b0;
        rd(32'h30000, 8'h42);
        rd(32'h30000, 8'h00);
        for (int i = 0; i < 17; i++) begin
            rx_valid = 1'b1; rx_data = 8'(8'h80 + i);
            cyc();
        end
        rx_valid = 1'b0;
        for (int i = 0; i < 16; i++) rd(32'h30000, 8'(8'h80 + i));
        rd(32'h30000, 8'h00);

        // Halt with two bytes pending
        tx_ready = 1'b0;
        tx_wr(8'h11); tx_wr(8'h22);
        tx_exp.push_back(8'h00);
        wr(32'h30004, 8'h99);
        @(negedge clk_in);
        check("halt_not_done", {31'h0, program_done}, 32'h0);
        cyc();
        tx_ready = 1'b1;
        wait_tx_empty("halt_drain");
        check("done_lag", {31'h0, program_done}, 32'h0);
        @(negedge clk_in);
        check("done_rise", {31'h0, program_done}, 32'h1);
        cyc();
        rd_snap();
        repeat (5) cyc();
        rd_snap();
        check("halt_tx_sent", tx_exp.size(), 32'h0);

        // Reset mid-operation discards pending TX bytes, halt and overflow
        tx_ready = 1'b0;
        wr(32'h30000, 8'h5A); wr(32'h30000, 8'h5B);
        rst_in = 1'b1;
        cyc(); cyc();
        @(negedge clk_in);
        check("rst2_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst2_prog_done", {31'h0, program_done}, 32'h0);
        check("rst2_overflow", {31'h0, tx_overflow}, 32'h0);
        check("rst2_cpu_din", {24'h0, cpu_din}, 32'h0);
        cyc();
        rst_in = 1'b0;
        tx_ready = 1'b1;
        repeat (3) cyc();
        @(negedge clk_in);
        check("rst2_fifo_empty", {31'h0, tx_valid}, 32'h0);
        cyc();
        rd_snap();
        repeat (3) cyc();
        check("rd_all_done", rd_exp.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
